// File: rtl/zorro_bus_master.sv
// Zorro II / 68000 bus initiator: arbitrates (BR/BG/BGACK), runs one word/byte cycle per command,
// terminates on DTACK_n or BERR_n. Define BUS_TIMEOUT_EN to abort S_WAIT after TIMEOUT_CYCLES.
module zorro_bus_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [22:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic        cmd_uds,
  input  logic        cmd_lds,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        BR_n,
  output logic        BGACK_n,
  input  logic        BG_n,
  input  logic        AS_IN_n,
  input  logic        BGACK_IN_n,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW,
  output logic [22:0] ADDR_OUT,
  output logic [15:0] DOUT,
  input  logic [15:0] DIN,
  output logic        BUS_OE,
  output logic        DATA_OE
);

  typedef enum logic [2:0] {IDLE, REQ, OWN, S_ADDR, S_DS, S_WAIT, S_TERM, S_HOLD} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic bg_s, as_in_s, bgack_in_s, dtack_s, berr_s;

  always_ff @(posedge CLK) begin
    if (RESET) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], {BG_n, AS_IN_n, BGACK_IN_n, DTACK_n, BERR_n}};
  end
  assign {bg_s, as_in_s, bgack_in_s, dtack_s, berr_s} = sync_q[SYNC_STAGES-1];

  logic        pend_q, pend_d, cw_q, cw_d, cuds_q, cuds_d, clds_q, clds_d;
  logic [22:0] caddr_q, caddr_d;
  logic [15:0] cwdata_q, cwdata_d, rdata_q, rdata_d;
  logic        br_n_q, br_n_d, bgack_n_q, bgack_n_d, as_n_q, as_n_d;
  logic        uds_n_q, uds_n_d, lds_n_q, lds_n_d, rw_q, rw_d;
  logic        bus_oe_q, bus_oe_d, data_oe_q, data_oe_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        accept, no_strobe;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // A command accepted in OWN while idle on the bus is parked in pend_q; the next OWN cycle starts it.
  assign cmd_ready = (state_q == IDLE) || (state_q == OWN && !pend_q);
  assign accept    = cmd_valid && cmd_ready;
  assign no_strobe = !cmd_uds && !cmd_lds;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cw_d        = cw_q;
    cuds_d      = cuds_q;
    clds_d      = clds_q;
    caddr_d     = caddr_q;
    cwdata_d    = cwdata_q;
    rdata_d     = rdata_q;
    br_n_d      = br_n_q;
    bgack_n_d   = bgack_n_q;
    as_n_d      = as_n_q;
    uds_n_d     = uds_n_q;
    lds_n_d     = lds_n_q;
    rw_d        = rw_q;
    bus_oe_d    = bus_oe_q;
    data_oe_d   = data_oe_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    if (accept) begin
      cw_d     = cmd_write;
      cuds_d   = cmd_uds;
      clds_d   = cmd_lds;
      caddr_d  = cmd_addr;
      cwdata_d = cmd_wdata;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (no_strobe) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d = REQ;
            br_n_d  = 1'b0;
            pend_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (!bg_s && as_in_s && bgack_in_s) begin
          state_d   = OWN;
          bgack_n_d = 1'b0;
          br_n_d    = 1'b1;
        end
      end
      OWN: begin
        if (pend_q) begin
          state_d  = S_ADDR;
          pend_d   = 1'b0;
          bus_oe_d = 1'b1;
          rw_d     = !cw_q;
        end else if (accept) begin
          if (no_strobe) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
          end else begin
            pend_d = 1'b1;
          end
        end else begin
          state_d   = IDLE;
          bgack_n_d = 1'b1;
          bus_oe_d  = 1'b0;
        end
      end
      S_ADDR: begin
        state_d = S_DS;
        as_n_d  = 1'b0;
        if (cw_q) begin
          data_oe_d = 1'b1;
        end else begin
          uds_n_d = !cuds_q;
          lds_n_d = !clds_q;
        end
      end
      S_DS: begin
        state_d = S_WAIT;
        if (cw_q) begin
          uds_n_d = !cuds_q;
          lds_n_d = !clds_q;
        end
`ifdef BUS_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      S_WAIT: begin
        // BERR is checked first so it wins over a simultaneous DTACK.
        if (!berr_s) begin
          state_d   = S_TERM;
          rsp_err_d = 1'b1;
          rdata_d   = '0;
        end else if (!dtack_s) begin
          state_d   = S_TERM;
          rsp_err_d = 1'b0;
          rdata_d   = cw_q ? 16'h0000 : DIN;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_TERM;
          rsp_err_d = 1'b1;
          rdata_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_TERM: begin
        state_d     = S_HOLD;
        as_n_d      = 1'b1;
        uds_n_d     = 1'b1;
        lds_n_d     = 1'b1;
        rsp_valid_d = 1'b1;
      end
      S_HOLD: begin
        rw_d      = 1'b1;
        data_oe_d = 1'b0;
        if (dtack_s && berr_s) state_d = OWN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      cw_q        <= 1'b0;
      cuds_q      <= 1'b0;
      clds_q      <= 1'b0;
      caddr_q     <= '0;
      cwdata_q    <= '0;
      rdata_q     <= '0;
      br_n_q      <= 1'b1;
      bgack_n_q   <= 1'b1;
      as_n_q      <= 1'b1;
      uds_n_q     <= 1'b1;
      lds_n_q     <= 1'b1;
      rw_q        <= 1'b1;
      bus_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cw_q        <= cw_d;
      cuds_q      <= cuds_d;
      clds_q      <= clds_d;
      caddr_q     <= caddr_d;
      cwdata_q    <= cwdata_d;
      rdata_q     <= rdata_d;
      br_n_q      <= br_n_d;
      bgack_n_q   <= bgack_n_d;
      as_n_q      <= as_n_d;
      uds_n_q     <= uds_n_d;
      lds_n_q     <= lds_n_d;
      rw_q        <= rw_d;
      bus_oe_q    <= bus_oe_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign BR_n      = br_n_q;
  assign BGACK_n   = bgack_n_q;
  assign AS_n      = as_n_q;
  assign UDS_n     = uds_n_q;
  assign LDS_n     = lds_n_q;
  assign RW        = rw_q;
  assign ADDR_OUT  = caddr_q;
  assign DOUT      = cwdata_q;
  assign BUS_OE    = bus_oe_q;
  assign DATA_OE   = data_oe_q;

endmodule

// File: tb/tb_zorro_bus_master.sv
// Directed bench for zorro_bus_master: reset, read, write, back-to-back, BERR, zero-strobe,
// reset mid-cycle and S_WAIT timeout behaviour (BUS_TIMEOUT_EN aware).
module tb_zorro_bus_master;
  logic        CLK = 1'b0;
  logic        RESET, cmd_valid, cmd_ready, cmd_write, cmd_uds, cmd_lds;
  logic [22:0] cmd_addr, ADDR_OUT;
  logic [15:0] cmd_wdata, rsp_rdata, DOUT, DIN;
  logic        rsp_valid, rsp_err, BR_n, BGACK_n, BG_n, AS_IN_n, BGACK_IN_n, DTACK_n, BERR_n;
  logic        AS_n, UDS_n, LDS_n, RW, BUS_OE, DATA_OE;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  zorro_bus_master dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_uds(cmd_uds), .cmd_lds(cmd_lds),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .BR_n(BR_n), .BGACK_n(BGACK_n), .BG_n(BG_n), .AS_IN_n(AS_IN_n), .BGACK_IN_n(BGACK_IN_n),
    .DTACK_n(DTACK_n), .BERR_n(BERR_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .ADDR_OUT(ADDR_OUT), .DOUT(DOUT), .DIN(DIN), .BUS_OE(BUS_OE), .DATA_OE(DATA_OE)
  );

  always #5 CLK = ~CLK;

  // Bus ownership rules: strobes and drivers only while BGACK_n is held low.
  always @(negedge CLK) begin
    if (RESET === 1'b0 && BGACK_n === 1'b1 && (AS_n === 1'b0 || BUS_OE === 1'b1)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int s);
    case (s)
      0: return BR_n;
      1: return BGACK_n;
      2: return AS_n;
      3: return rsp_valid;
      4: return DATA_OE;
      default: return 1'bx;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int s, input logic v);
    int n = 0;
    while (pick(s) !== v && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic issue(input logic w, input logic [22:0] a, input logic [15:0] d,
                       input logic u, input logic l);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_uds = u; cmd_lds = l;
  endtask

  task automatic grab(input string tag);
    wait_for({tag, "_br"}, 0, 1'b0);
    BG_n = 1'b0;
    wait_for({tag, "_gnt"}, 1, 1'b0);
    BG_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, extra, seen, rsp_cnt, br_again, bg_rel, hold_bad;
    logic granted, drop_next;
    logic [15:0] rd0, rd1;

    RESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_uds = 1'b0; cmd_lds = 1'b0; BG_n = 1'b1; AS_IN_n = 1'b1; BGACK_IN_n = 1'b1;
    DTACK_n = 1'b1; BERR_n = 1'b1; DIN = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_br", BR_n, 1); chk("rst_bgack", BGACK_n, 1); chk("rst_as", AS_n, 1);
    chk("rst_uds", UDS_n, 1); chk("rst_lds", LDS_n, 1); chk("rst_rw", RW, 1);
    chk("rst_oe", BUS_OE, 0); chk("rst_doe", DATA_OE, 0); chk("rst_rdy", cmd_ready, 1);
    chk("rst_rv", rsp_valid, 0); chk("rst_err", rsp_err, 0); chk("rst_rd", rsp_rdata, 0);
    chk("rst_addr", ADDR_OUT, 0);

    // Read 0xE80000, grant 3 cycles after BR_n, DTACK 4 cycles after AS_n falls.
    @(negedge CLK);
    issue(1'b0, 23'h740000, 16'h0000, 1'b1, 1'b1);
    @(negedge CLK);
    chk("t1_br", BR_n, 0); chk("t1_rdy", cmd_ready, 0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge CLK);
    BG_n = 1'b0;
    wait_for("t1_gnt", 1, 1'b0);
    chk("t1_br_rel", BR_n, 1);
    BG_n = 1'b1;
    @(negedge CLK);
    chk("t1_oe", BUS_OE, 1); chk("t1_addr", ADDR_OUT, 32'h740000); chk("t1_rw", RW, 1);
    chk("t1_as_pre", AS_n, 1);
    @(negedge CLK);
    chk("t1_as", AS_n, 0); chk("t1_uds", UDS_n, 0); chk("t1_lds", LDS_n, 0);
    repeat (4) @(negedge CLK);
    DTACK_n = 1'b0; DIN = 16'hA5C3;
    n = 4;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("t1_lat", n, 8); chk("t1_rd", rsp_rdata, 16'hA5C3); chk("t1_err", rsp_err, 0);
    chk("t1_as_rel", AS_n, 1);
    DTACK_n = 1'b1; DIN = 16'h0000;
    extra = 0; k = 0;
    while (BGACK_n !== 1'b1 && k < 40) begin
      @(negedge CLK);
      k++;
      if (rsp_valid === 1'b1) extra++;
    end
    chk("t1_once", extra, 0); chk("t1_idle_oe", BUS_OE, 0); chk("t1_idle_to", 32'(k < 40), 1);

    // Write 0xEF0002 = 0x1234, lower byte only.
    issue(1'b1, 23'h778001, 16'h1234, 1'b0, 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    grab("t2");
    wait_for("t2_doe", 4, 1'b1);
    chk("t2_dout", DOUT, 16'h1234); chk("t2_lds_pre", LDS_n, 1); chk("t2_uds_pre", UDS_n, 1);
    chk("t2_rw", RW, 0); chk("t2_as", AS_n, 0);
    @(negedge CLK);
    chk("t2_lds", LDS_n, 0); chk("t2_uds", UDS_n, 1); chk("t2_doe_hold", DATA_OE, 1);
    DTACK_n = 1'b0;
    wait_for("t2_rsp", 3, 1'b1);
    chk("t2_err", rsp_err, 0); chk("t2_rd", rsp_rdata, 0);
    DTACK_n = 1'b1;
    wait_for("t2_idle", 1, 1'b1);
    chk("t2_doe_rel", DATA_OE, 0);

    // Two queued reads: bus kept between them, no re-arbitration.
    issue(1'b0, 23'h000100, 16'h0000, 1'b1, 1'b1);
    @(negedge CLK);
    cmd_addr = 23'h000101;
    rsp_cnt = 0; br_again = 0; bg_rel = 0; granted = 1'b0; drop_next = 1'b0;
    rd0 = '0; rd1 = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      if (drop_next) begin
        cmd_valid = 1'b0;
        drop_next = 1'b0;
      end else if (cmd_valid && cmd_ready === 1'b1) begin
        drop_next = 1'b1;
      end
      if (!granted) begin
        if (BR_n === 1'b0) BG_n = 1'b0;
        if (BGACK_n === 1'b0) begin
          granted = 1'b1;
          BG_n = 1'b1;
        end
      end else begin
        if (BR_n === 1'b0) br_again++;
        if (BGACK_n === 1'b1 && rsp_cnt < 2) bg_rel++;
      end
      if (AS_n === 1'b0) begin
        DTACK_n = 1'b0;
        DIN = (rsp_cnt == 0) ? 16'h1111 : 16'h2222;
      end else begin
        DTACK_n = 1'b1;
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_cnt == 0) rd0 = rsp_rdata;
        else              rd1 = rsp_rdata;
        rsp_cnt++;
      end
      if (rsp_cnt == 2 && BGACK_n === 1'b1) break;
    end
    DTACK_n = 1'b1;
    chk("t3_rsp_cnt", rsp_cnt, 2); chk("t3_rd0", rd0, 16'h1111); chk("t3_rd1", rd1, 16'h2222);
    chk("t3_br_again", br_again, 0); chk("t3_bgack_rel", bg_rel, 0);

    // BERR and DTACK together: error wins, S_HOLD waits for both to negate.
    issue(1'b0, 23'h000200, 16'h0000, 1'b1, 1'b0);
    @(negedge CLK);
    cmd_valid = 1'b0;
    grab("t4");
    wait_for("t4_as", 2, 1'b0);
    DTACK_n = 1'b0; BERR_n = 1'b0; DIN = 16'hBEEF;
    wait_for("t4_rsp", 3, 1'b1);
    chk("t4_err", rsp_err, 1); chk("t4_rd", rsp_rdata, 0);
    DTACK_n = 1'b1;
    hold_bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (BUS_OE !== 1'b1 || BGACK_n !== 1'b0) hold_bad++;
    end
    chk("t4_hold", hold_bad, 0);
    BERR_n = 1'b1;
    wait_for("t4_idle", 1, 1'b1);

    // No byte strobes: immediate error response, no arbitration.
    issue(1'b0, 23'h000300, 16'h0000, 1'b0, 1'b0);
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("t5_rv", rsp_valid, 1); chk("t5_err", rsp_err, 1); chk("t5_br", BR_n, 1);
    @(negedge CLK);
    chk("t5_rv_pulse", rsp_valid, 0);

    // Reset while parked in S_WAIT.
    issue(1'b0, 23'h000300, 16'h0000, 1'b1, 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    grab("t6");
    wait_for("t6_as", 2, 1'b0);
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("t6_as", AS_n, 1); chk("t6_bgack", BGACK_n, 1); chk("t6_oe", BUS_OE, 0);
    chk("t6_rdy", cmd_ready, 1); chk("t6_rv", rsp_valid, 0);
    RESET = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (rsp_valid === 1'b1) seen++;
    end
    chk("t6_no_rsp", seen, 0);

    // No DTACK at all.
    issue(1'b0, 23'h000400, 16'h0000, 1'b1, 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    grab("t7");
    wait_for("t7_as", 2, 1'b0);
`ifdef BUS_TIMEOUT_EN
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("t7_tmo_lat", n, 66); chk("t7_err", rsp_err, 1); chk("t7_rd", rsp_rdata, 0);
`else
    seen = 0;
    repeat (100) begin
      @(negedge CLK);
      if (rsp_valid === 1'b1) seen++;
    end
    chk("t7_no_rsp", seen, 0); chk("t7_as_held", AS_n, 0);
    DTACK_n = 1'b0; DIN = 16'h5A5A;
    wait_for("t7_rsp", 3, 1'b1);
    chk("t7_rd", rsp_rdata, 16'h5A5A); chk("t7_err", rsp_err, 0);
    DTACK_n = 1'b1;
`endif
    wait_for("t7_idle", 1, 1'b1);
    chk("ownership", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
